// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types and constants for the data-memory responder:
//   mem_in_type / mem_out_type   request and response records of the port
//   dmem_state_type              responder FSM states
//   dmem_responder_reg_type      complete registered state of the responder
//   init_dmem_responder_reg      reset value of that state
//   is_store()                   access-kind decode from the byte strobes
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_type;

  // Captured request plus the registered response flags. rd_sel marks a
  // cycle in which the RAM output is the load data to be returned.
  typedef struct packed {
    dmem_state_type state;
    logic [3:0]     cnt;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic [3:0]     wstrb;
    logic           fence;
    logic           spec;
    logic           instr;
    logic           store;
    logic           ready;
    logic           err;
    logic           rd_sel;
  } dmem_responder_reg_type;

  localparam dmem_responder_reg_type init_dmem_responder_reg = '{
    state:  IDLE,
    cnt:    4'd0,
    addr:   32'd0,
    wdata:  32'd0,
    wstrb:  4'd0,
    fence:  1'b0,
    spec:   1'b0,
    instr:  1'b0,
    store:  1'b0,
    ready:  1'b0,
    err:    1'b0,
    rd_sel: 1'b0
  };

  // Any enabled byte lane makes the access a store.
  function automatic logic is_store(input logic [3:0] wstrb);
    return (wstrb != 4'h0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Data-memory port between the decode-side initiator and the responder.
//   dmem_in   request record (initiator -> responder)
//   dmem_out  response record: mem_ready pulse and mem_rdata
//   dmem_err  out-of-range flag, pulses together with mem_ready
// Modports: master = initiator side, slave = responder side.
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  mem_in_type  dmem_in;
  mem_out_type dmem_out;
  logic        dmem_err;

  modport master (
    output dmem_in,
    input  dmem_out,
    input  dmem_err
  );

  modport slave (
    input  dmem_in,
    output dmem_out,
    output dmem_err
  );

endinterface

// File: rtl/dmem_responder_data_ram.sv
// ---------------------------------------------------------------------------
// data_ram
// Single-port synchronous word RAM with per-byte write enables.
//   clock  rising-edge clock
//   en     access enable; rdata is updated only on enabled cycles
//   wstrb  byte-lane write enables (all zero = pure read)
//   index  word index
//   wdata  write data
//   rdata  registered read data, one cycle after the access (old contents
//          on a simultaneous write)
// Contents are not reset.
// ---------------------------------------------------------------------------
module data_ram #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic [3:0]            wstrb,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Responder end of the data-memory port. Accepts load, store and fence
// requests, serves loads/stores from an internal word RAM after WAIT_STATES
// extra cycles and returns a one-cycle mem_ready pulse with mem_rdata and
// an out-of-range flag.
//   reset  asynchronous active-low reset
//   clock  rising-edge clock
//   dmem   slave side of dmem_responder_if (dmem_in / dmem_out / dmem_err)
// Parameters:
//   DEPTH_LOG2   log2 of the RAM depth in 32-bit words
//   BASE_ADDR    byte address of word 0, aligned to the RAM size
//   WAIT_STATES  extra cycles between accept and response (0..15)
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h00010000,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic            reset,
  input logic            clock,
  dmem_responder_if.slave dmem
);
  import dmem_responder_pkg::*;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_responder_reg_type r_q;
  dmem_responder_reg_type r_d;

  logic [31:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] ram_index;
  logic                  ram_en;
  logic [3:0]            ram_wstrb;
  logic [31:0]           ram_rdata;
  logic                  unused_bits;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset    = r_q.addr - BASE_ADDR;
  assign in_range  = (offset[31:DEPTH_LOG2+2] == '0);
  assign ram_index = offset[DEPTH_LOG2+1:2];

  // Reserved request bits and the byte offset inside the word carry no
  // function; lane selection comes only from the strobes.
  assign unused_bits = ^{r_q.spec, r_q.instr, offset[1:0]};

  always_comb begin
    dmem_responder_reg_type v;
    mem_in_type             req;
    logic                   accept;

    v         = r_q;
    req       = dmem.dmem_in;
    accept    = 1'b0;
    ram_en    = 1'b0;
    ram_wstrb = '0;
    v.ready   = 1'b0;
    v.err     = 1'b0;
    v.rd_sel  = 1'b0;

    unique case (r_q.state)
      IDLE: begin
        accept = req.mem_valid;
      end
      WAIT: begin
        if (r_q.cnt == '0) begin
          v.state = RESP;
        end else begin
          v.cnt = r_q.cnt - 4'd1;
        end
      end
      RESP: begin
        // The RAM access happens on the edge that leaves RESP, so a store
        // commits before any back-to-back load reads at its own RESP edge.
        v.ready = 1'b1;
        v.state = IDLE;
        if (!r_q.fence) begin
          if (in_range) begin
            ram_en = 1'b1;
            if (r_q.store) begin
              ram_wstrb = r_q.wstrb;
            end else begin
              v.rd_sel = 1'b1;
            end
          end else begin
            v.err = 1'b1;
          end
        end
        accept = req.mem_valid;
      end
      default: begin
        v.state = IDLE;
      end
    endcase

    if (accept) begin
      v.addr  = req.mem_addr;
      v.wdata = req.mem_wdata;
      v.wstrb = req.mem_wstrb;
      v.fence = req.mem_fence;
      v.spec  = req.mem_spec;
      v.instr = req.mem_instr;
      v.store = is_store(req.mem_wstrb);
      v.cnt   = WAIT_LOAD;
      if (WAIT_STATES > 0) begin
        v.state = WAIT;
      end else begin
        v.state = RESP;
      end
    end

    r_d = v;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= init_dmem_responder_reg;
    end else begin
      r_q <= r_d;
    end
  end

  data_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_data_ram (
    .clock (clock),
    .en    (ram_en),
    .wstrb (ram_wstrb),
    .index (ram_index),
    .wdata (r_q.wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register is not reset, so load data is gated by the
  // registered rd_sel flag; mem_rdata is zero outside a load response.
  assign dmem.dmem_out = '{mem_ready: r_q.ready,
                           mem_rdata: (r_q.rd_sel ? ram_rdata : 32'h0)};
  assign dmem.dmem_err = r_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  dmem_responder_if if0();
  dmem_responder_if if1();

  dmem_responder #(
    .DEPTH_LOG2 (10),
    .BASE_ADDR  (32'h00010000),
    .WAIT_STATES(0)
  ) dut0 (
    .reset(rst_n),
    .clock(clk),
    .dmem (if0)
  );

  dmem_responder #(
    .DEPTH_LOG2 (10),
    .BASE_ADDR  (32'h00010000),
    .WAIT_STATES(3)
  ) dut1 (
    .reset(rst_n),
    .clock(clk),
    .dmem (if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int u, input logic v, input logic f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    mem_in_type r;
    r = '{mem_valid: v, mem_fence: f, mem_spec: 1'b0, mem_instr: 1'b0,
          mem_addr: a, mem_wdata: wd, mem_wstrb: ws};
    if (u == 0) if0.dmem_in = r;
    else        if1.dmem_in = r;
  endtask

  // Request driven now is accepted at the next edge; ready is then seen
  // WAIT_STATES+1 edges later.
  task automatic expect_rsp(input int u, input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    if (u == 0) begin
      e.cyc = cyc + 0 + 2;
      q0.push_back(e);
    end else begin
      e.cyc = cyc + 3 + 2;
      q1.push_back(e);
    end
  endtask

  task automatic issue(input int u, input logic f, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] rd, input logic er);
    set_req(u, 1'b1, f, a, wd, ws);
    expect_rsp(u, rd, er);
    step();
    set_req(u, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if0.dmem_out.mem_ready === 1'b1) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u0_spurious_ready: got ready=1 at cycle %0d expected no response", cyc);
      end else begin
        e = q0.pop_front();
        chk("u0_latency", cyc, e.cyc);
        chk("u0_rdata", if0.dmem_out.mem_rdata, e.rdata);
        chk("u0_err", {31'b0, if0.dmem_err}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.dmem_out.mem_ready === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u1_spurious_ready: got ready=1 at cycle %0d expected no response", cyc);
      end else begin
        e = q1.pop_front();
        chk("u1_latency", cyc, e.cyc);
        chk("u1_rdata", if1.dmem_out.mem_rdata, e.rdata);
        chk("u1_err", {31'b0, if1.dmem_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1, "time limit");
  end

  initial begin
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) step();

    chk("rst_u0_ready", {31'b0, if0.dmem_out.mem_ready}, 32'h0);
    chk("rst_u0_rdata", if0.dmem_out.mem_rdata, 32'h0);
    chk("rst_u0_err",   {31'b0, if0.dmem_err}, 32'h0);
    chk("rst_u1_ready", {31'b0, if1.dmem_out.mem_ready}, 32'h0);
    chk("rst_u1_rdata", if1.dmem_out.mem_rdata, 32'h0);
    chk("rst_u1_err",   {31'b0, if1.dmem_err}, 32'h0);

    #2 rst_n = 1'b1;
    step();

    // Zero wait states: store then back-to-back load of the same word.
    issue(0, 1'b0, 32'h00010004, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h00010004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    repeat (2) step();

    // Byte-lane write merges into the existing word.
    issue(0, 1'b0, 32'h00010008, 32'h11223344, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h00010008, 32'h00AA0000, 4'b0100, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h00010008, 32'h0, 4'h0, 32'h11AA3344, 1'b0);
    issue(0, 1'b0, 32'h0001000B, 32'h0, 4'h0, 32'h11AA3344, 1'b0);

    // Words that a wrong index decode of the out-of-range stores would hit.
    issue(0, 1'b0, 32'h00010000, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h00010FFC, 32'h12345678, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h00000FFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h00011000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h00011000, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h00010000, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
    issue(0, 1'b0, 32'h00010FFC, 32'h0, 4'h0, 32'h12345678, 1'b0);

    // Fences: no RAM access and never an error.
    issue(0, 1'b1, 32'h00010004, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h00011000, 32'h0, 4'h0, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h00010004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    repeat (3) step();

    // Three wait states: preload, accepts land on RESP edges.
    issue(1, 1'b0, 32'h00010010, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
    repeat (3) step();
    issue(1, 1'b0, 32'h00010014, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0);
    repeat (3) step();
    issue(1, 1'b0, 32'h00010018, 32'h01020304, 4'hF, 32'h0, 1'b0);
    repeat (5) step();

    // Held load; a store shown during WAIT must be ignored; a new load in
    // the RESP cycle is accepted back-to-back and sees the untouched word.
    set_req(1, 1'b1, 1'b0, 32'h00010010, 32'h0, 4'h0);
    expect_rsp(1, 32'hA5A5A5A5, 1'b0);
    step();
    set_req(1, 1'b1, 1'b0, 32'h00010014, 32'hFFFFFFFF, 4'hF);
    repeat (3) step();
    set_req(1, 1'b1, 1'b0, 32'h00010014, 32'h0, 4'h0);
    expect_rsp(1, 32'h5A5A5A5A, 1'b0);
    step();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (6) step();

    // Reset while u1 holds a store in WAIT and u0 is presenting a response.
    set_req(1, 1'b1, 1'b0, 32'h00010018, 32'hFFFFFFFF, 4'hF);
    set_req(0, 1'b1, 1'b0, 32'h00010004, 32'h0, 4'h0);
    step();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_u0_ready", {31'b0, if0.dmem_out.mem_ready}, 32'h0);
    chk("arst_u0_rdata", if0.dmem_out.mem_rdata, 32'h0);
    chk("arst_u0_err",   {31'b0, if0.dmem_err}, 32'h0);
    chk("arst_u1_ready", {31'b0, if1.dmem_out.mem_ready}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    issue(1, 1'b0, 32'h00010018, 32'h0, 4'h0, 32'h01020304, 1'b0);
    repeat (5) step();
    issue(0, 1'b0, 32'h00010004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    repeat (10) step();

    chk("u0_pending_left", q0.size(), 32'h0);
    chk("u1_pending_left", q1.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
